// File: rtl/awmc_pkg.sv
// awmc_pkg
// Shared definitions for the washing-machine program controller.
// Holds the stage encoding, the wash-mode encodings, the default stage
// durations and a helper that turns a duration into a down-counter load value.
package awmc_pkg;

    // Stage codes are visible on the stage output, so the values are fixed.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } stage_t;

    // Wash modes; the fourth encoding behaves as normal.
    localparam logic [1:0] MODE_QUICK  = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;

    // Default durations and fill/drain timeout, in clock cycles.
    localparam int unsigned DEF_WASH_T_QUICK  = 20;
    localparam int unsigned DEF_WASH_T_NORMAL = 40;
    localparam int unsigned DEF_WASH_T_HEAVY  = 80;
    localparam int unsigned DEF_RINSE_T       = 16;
    localparam int unsigned DEF_SPIN_T        = 24;
    localparam int unsigned DEF_FILL_TMO      = 64;

    // The timer is loaded on entry to a stage and the stage ends on the
    // cycle it reads zero, so a stage of N cycles loads N-1. A duration of
    // zero is treated as a single cycle.
    function automatic int unsigned dur_to_load(input int unsigned dur);
        return (dur == 0) ? 0 : dur - 1;
    endfunction

endpackage

// File: rtl/awmc_timer.sv
// awmc_timer
// Loadable, freezable down-counter with a saturating zero flag.
// Used for stage durations and for the fill/drain watchdog.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset, clears the count
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one; ignored once the count is zero
//   zero     - high while the count is zero
module awmc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // The count holds at zero instead of wrapping, so a late or repeated
    // decrement can never turn an expired timer back into a long one.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/awmc_prog.sv
// awmc_prog
// Washing-machine program sequencer: FILL, WASH, DRAIN, optional
// FILL/RINSE/DRAIN loops, SPIN, DONE. Stage timing is counted only on
// unfrozen cycles; pause=1 or an open lid freezes the program.
//
// Optional feature: define AWMC_PROG_WATCHDOG_EN to enable the fill/drain
// timeout that drops the program into FAULT. Without it FILL and DRAIN wait
// forever for their sensor and fault is tied low.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   start                - begins a program when sampled high in IDLE
//   pause                - freezes the program while high
//   lid                  - 1 = lid closed
//   mode                 - 0 quick, 1 normal, 2 heavy, 3 normal
//   rinse_cnt            - number of rinse passes
//   level_full/empty     - water-level sensors
//   stage                - current stage code
//   input_valve, output_drain, motor - actuator enables (registered)
//   done                 - one-cycle completion pulse
//   rinse_left           - rinse passes still to run
//   fault                - fill/drain timeout flag
module awmc_prog
    import awmc_pkg::*;
#(
    parameter int          TIME_W        = 8,
    parameter int          RC_W          = 2,
    parameter int unsigned WASH_T_QUICK  = DEF_WASH_T_QUICK,
    parameter int unsigned WASH_T_NORMAL = DEF_WASH_T_NORMAL,
    parameter int unsigned WASH_T_HEAVY  = DEF_WASH_T_HEAVY,
    parameter int unsigned RINSE_T       = DEF_RINSE_T,
    parameter int unsigned SPIN_T        = DEF_SPIN_T,
    parameter int unsigned FILL_TMO      = DEF_FILL_TMO
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            pause,
    input  logic            lid,
    input  logic [1:0]      mode,
    input  logic [RC_W-1:0] rinse_cnt,
    input  logic            level_full,
    input  logic            level_empty,
    output logic [2:0]      stage,
    output logic            input_valve,
    output logic            output_drain,
    output logic            motor,
    output logic            done,
    output logic [RC_W-1:0] rinse_left,
    output logic            fault
);

    localparam logic [TIME_W-1:0] WASH_Q_LD = TIME_W'(dur_to_load(WASH_T_QUICK));
    localparam logic [TIME_W-1:0] WASH_N_LD = TIME_W'(dur_to_load(WASH_T_NORMAL));
    localparam logic [TIME_W-1:0] WASH_H_LD = TIME_W'(dur_to_load(WASH_T_HEAVY));
    localparam logic [TIME_W-1:0] RINSE_LD  = TIME_W'(dur_to_load(RINSE_T));
    localparam logic [TIME_W-1:0] SPIN_LD   = TIME_W'(dur_to_load(SPIN_T));

    stage_t            state;
    logic [1:0]        mode_q;
    logic              first_fill;
    logic              frozen;
    logic [TIME_W-1:0] wash_ld;
    logic              st_load;
    logic [TIME_W-1:0] st_val;
    logic              st_dec;
    logic              st_zero;

    assign stage = state;

    // Freeze applies only to the active stages; IDLE, DONE and FAULT ignore it.
    always_comb begin
        frozen = 1'b0;
        if (state inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN}) begin
            frozen = pause || !lid;
        end
    end

    // Wash length for the mode captured at start; mode 3 runs as normal.
    always_comb begin
        case (mode_q)
            MODE_QUICK: wash_ld = WASH_Q_LD;
            MODE_HEAVY: wash_ld = WASH_H_LD;
            default:    wash_ld = WASH_N_LD;
        endcase
    end

    // Stage timer control: load on the edge that enters a timed stage,
    // count down on every unfrozen cycle spent inside one.
    always_comb begin
        st_load = 1'b0;
        st_val  = '0;
        st_dec  = 1'b0;
        if (!frozen) begin
            case (state)
                S_FILL: begin
                    if (level_full) begin
                        st_load = 1'b1;
                        st_val  = first_fill ? wash_ld : RINSE_LD;
                    end
                end
                S_DRAIN: begin
                    if (level_empty && (rinse_left == '0)) begin
                        st_load = 1'b1;
                        st_val  = SPIN_LD;
                    end
                end
                S_WASH, S_RINSE, S_SPIN: st_dec = 1'b1;
                default: ;
            endcase
        end
    end

    awmc_timer #(.W(TIME_W)) u_stage_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (st_load),
        .load_val (st_val),
        .dec      (st_dec),
        .zero     (st_zero)
    );

`ifdef AWMC_PROG_WATCHDOG_EN
    localparam logic [TIME_W-1:0] WD_LD = TIME_W'(dur_to_load(FILL_TMO));

    logic wd_load;
    logic wd_dec;
    logic wd_zero;

    // The watchdog sits preloaded outside FILL/DRAIN and is reloaded when a
    // sensor ends the stage, so every FILL and DRAIN starts a fresh timeout.
    always_comb begin
        wd_load = 1'b1;
        wd_dec  = 1'b0;
        if (state == S_FILL) begin
            wd_load = !frozen && level_full;
            wd_dec  = !frozen;
        end else if (state == S_DRAIN) begin
            wd_load = !frozen && level_empty;
            wd_dec  = !frozen;
        end
    end

    awmc_timer #(.W(TIME_W)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (WD_LD),
        .dec      (wd_dec),
        .zero     (wd_zero)
    );
`else
    assign fault = 1'b0;
`endif

    // Program sequencer. Actuator outputs are registered and describe the
    // stage being entered or held; a frozen cycle holds everything and
    // drives all actuators low. FAULT is left only through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= '0;
            first_fill   <= 1'b0;
            rinse_left   <= '0;
            input_valve  <= 1'b0;
            output_drain <= 1'b0;
            motor        <= 1'b0;
            done         <= 1'b0;
`ifdef AWMC_PROG_WATCHDOG_EN
            fault        <= 1'b0;
`endif
        end else begin
            input_valve  <= 1'b0;
            output_drain <= 1'b0;
            motor        <= 1'b0;
            done         <= 1'b0;
            if (!frozen) begin
                case (state)
                    S_IDLE: begin
                        if (start && lid && !pause) begin
                            state       <= S_FILL;
                            input_valve <= 1'b1;
                            mode_q      <= mode;
                            rinse_left  <= rinse_cnt;
                            first_fill  <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (level_full) begin
                            first_fill <= 1'b0;
                            motor      <= 1'b1;
                            state      <= first_fill ? S_WASH : S_RINSE;
                        end
`ifdef AWMC_PROG_WATCHDOG_EN
                        else if (wd_zero) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end
`endif
                        else begin
                            input_valve <= 1'b1;
                        end
                    end
                    S_WASH: begin
                        if (st_zero) begin
                            state        <= S_DRAIN;
                            output_drain <= 1'b1;
                        end else begin
                            motor <= 1'b1;
                        end
                    end
                    S_RINSE: begin
                        if (st_zero) begin
                            state        <= S_DRAIN;
                            output_drain <= 1'b1;
                            rinse_left   <= rinse_left - 1'b1;
                        end else begin
                            motor <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (level_empty) begin
                            if (rinse_left != '0) begin
                                state       <= S_FILL;
                                input_valve <= 1'b1;
                            end else begin
                                state        <= S_SPIN;
                                motor        <= 1'b1;
                                output_drain <= 1'b1;
                            end
                        end
`ifdef AWMC_PROG_WATCHDOG_EN
                        else if (wd_zero) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end
`endif
                        else begin
                            output_drain <= 1'b1;
                        end
                    end
                    S_SPIN: begin
                        if (st_zero) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            motor        <= 1'b1;
                            output_drain <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    S_FAULT: begin
                        state <= S_FAULT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_awmc_prog.sv
// tb_awmc_prog
// Directed testbench for awmc_prog with default parameters. Expected stage
// lengths come from the default durations: quick 20, normal 40, heavy 80,
// rinse 16, spin 24, fill/drain timeout 64. The timeout section follows
// AWMC_PROG_WATCHDOG_EN.
module tb_awmc_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic       lid;
    logic [1:0] mode;
    logic [1:0] rinse_cnt;
    logic       level_full;
    logic       level_empty;
    logic [2:0] stage;
    logic       input_valve;
    logic       output_drain;
    logic       motor;
    logic       done;
    logic [1:0] rinse_left;
    logic       fault;

    int vectors     = 0;
    int miscompares = 0;
    int cyc, mot, drn, mot2;
    int hold_cnt, act_cnt;

    awmc_prog dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .lid          (lid),
        .mode         (mode),
        .rinse_cnt    (rinse_cnt),
        .level_full   (level_full),
        .level_empty  (level_empty),
        .stage        (stage),
        .input_valve  (input_valve),
        .output_drain (output_drain),
        .motor        (motor),
        .done         (done),
        .rinse_left   (rinse_left),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the control and sensor inputs in one go.
    task automatic applyStimulus(input logic st, input logic ps, input logic ld,
                                 input logic fl, input logic em);
        start       = st;
        pause       = ps;
        lid         = ld;
        level_full  = fl;
        level_empty = em;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Count cycles spent in stage s (bounded), plus motor and drain cycles.
    task automatic measure(input logic [2:0] s, input int bound,
                           output int c, output int m, output int d);
        c = 0;
        m = 0;
        d = 0;
        while (stage === s && c < bound) begin
            c++;
            if (motor) m++;
            if (output_drain) d++;
            step(1);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mode      = 2'd0;
        rinse_cnt = 2'd0;
        reset     = 1'b1;
        step(2);
        reset = 1'b0;
        checkOutput("reset_stage", 32'(stage), 32'd0);
        checkOutput("reset_outs", 32'({input_valve, output_drain, motor, done, fault}), 32'd0);
        checkOutput("reset_rinse_left", 32'(rinse_left), 32'd0);

        // Start is refused with the lid open or while paused
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        checkOutput("lid_open_idle", 32'(stage), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(2);
        checkOutput("paused_idle", 32'(stage), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Quick program, no rinse: FILL(3) WASH(20) DRAIN(2) SPIN(24) DONE
        mode      = 2'd0;
        rinse_cnt = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("a_fill_stage", 32'(stage), 32'd1);
        checkOutput("a_fill_valve", 32'(input_valve), 32'd1);
        step(2);
        checkOutput("a_fill_third", 32'(stage), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("a_wash_stage", 32'(stage), 32'd2);
        measure(3'd2, 200, cyc, mot, drn);
        checkOutput("a_wash_cycles", 32'(cyc), 32'd20);
        checkOutput("a_wash_motor", 32'(mot), 32'd20);
        checkOutput("a_drain_stage", 32'(stage), 32'd3);
        checkOutput("a_drain_out", 32'(output_drain), 32'd1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("a_spin_stage", 32'(stage), 32'd5);
        measure(3'd5, 200, cyc, mot, drn);
        checkOutput("a_spin_cycles", 32'(cyc), 32'd24);
        checkOutput("a_spin_motor", 32'(mot), 32'd24);
        checkOutput("a_spin_drain", 32'(drn), 32'd24);
        checkOutput("a_done_stage", 32'(stage), 32'd6);
        checkOutput("a_done_pulse", 32'(done), 32'd1);
        step(1);
        checkOutput("a_done_width", 32'(done), 32'd0);
        checkOutput("a_back_idle", 32'(stage), 32'd0);

        // Heavy program with two rinses
        mode      = 2'd2;
        rinse_cnt = 2'd2;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        checkOutput("b_rinse_left_load", 32'(rinse_left), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd2, 200, cyc, mot, drn);
        checkOutput("b_wash_cycles", 32'(cyc), 32'd80);
        for (int k = 0; k < 2; k++) begin
            checkOutput("b_drain_stage", 32'(stage), 32'd3);
            checkOutput("b_drain_rinse_left", 32'(rinse_left), 32'(2 - k));
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            step(1);
            checkOutput("b_refill_stage", 32'(stage), 32'd1);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            step(1);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("b_rinse_stage", 32'(stage), 32'd4);
            measure(3'd4, 200, cyc, mot, drn);
            checkOutput("b_rinse_cycles", 32'(cyc), 32'd16);
            checkOutput("b_rinse_motor", 32'(mot), 32'd16);
        end
        checkOutput("b_last_drain", 32'(stage), 32'd3);
        checkOutput("b_rinse_left_zero", 32'(rinse_left), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("b_spin_stage", 32'(stage), 32'd5);
        measure(3'd5, 200, cyc, mot, drn);
        checkOutput("b_spin_cycles", 32'(cyc), 32'd24);
        checkOutput("b_done_pulse", 32'(done), 32'd1);
        step(1);

        // Normal program paused for 10 cycles mid-wash
        mode      = 2'd1;
        rinse_cnt = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("c_wash_stage", 32'(stage), 32'd2);
        mot = 0;
        for (int i = 0; i < 11; i++) begin
            if (motor) mot++;
            if (i == 10) pause = 1'b1;
            step(1);
        end
        hold_cnt = 0;
        act_cnt  = 0;
        for (int j = 0; j < 10; j++) begin
            if (stage === 3'd2) hold_cnt++;
            if (motor || input_valve || output_drain) act_cnt++;
            if (j == 9) pause = 1'b0;
            step(1);
        end
        checkOutput("c_pause_hold", 32'(hold_cnt), 32'd10);
        checkOutput("c_pause_actuators", 32'(act_cnt), 32'd0);
        measure(3'd2, 200, cyc, mot2, drn);
        checkOutput("c_wash_motor_total", 32'(mot + mot2), 32'd40);
        checkOutput("c_drain_stage", 32'(stage), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd5, 200, cyc, mot, drn);
        checkOutput("c_spin_cycles", 32'(cyc), 32'd24);
        step(1);

        // Lid opened for one cycle during SPIN
        mode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd2, 200, cyc, mot, drn);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4);
        lid = 1'b0;
        step(1);
        checkOutput("d_lid_stage", 32'(stage), 32'd5);
        checkOutput("d_lid_motor", 32'(motor), 32'd0);
        checkOutput("d_lid_drain", 32'(output_drain), 32'd0);
        lid = 1'b1;
        measure(3'd5, 200, cyc, mot, drn);
        checkOutput("d_spin_rest_cycles", 32'(cyc), 32'd20);
        checkOutput("d_spin_rest_motor", 32'(mot), 32'd19);
        checkOutput("d_done_stage", 32'(stage), 32'd6);
        step(1);

        // Reset in the middle of a rinse
        mode      = 2'd0;
        rinse_cnt = 2'd1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd2, 200, cyc, mot, drn);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("e_rinse_stage", 32'(stage), 32'd4);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("e_reset_stage", 32'(stage), 32'd0);
        checkOutput("e_reset_outs", 32'({input_valve, output_drain, motor, done, fault}), 32'd0);
        checkOutput("e_reset_rinse_left", 32'(rinse_left), 32'd0);

        // Mode 3 runs as normal; start held high mid-program is ignored
        mode      = 2'd3;
        rinse_cnt = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd2, 200, cyc, mot, drn);
        checkOutput("f_mode3_wash_cycles", 32'(cyc), 32'd40);
        checkOutput("f_start_ignored", 32'(stage), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd5, 200, cyc, mot, drn);
        checkOutput("f_done_pulse", 32'(done), 32'd1);
        step(1);

`ifdef AWMC_PROG_WATCHDOG_EN
        // Fill never completes: timeout after 64 cycles, cleared by reset
        mode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        measure(3'd1, 300, cyc, mot, drn);
        checkOutput("g_fill_timeout_cycles", 32'(cyc), 32'd64);
        checkOutput("g_fault_stage", 32'(stage), 32'd7);
        checkOutput("g_fault_flag", 32'(fault), 32'd1);
        checkOutput("g_fault_actuators", 32'({input_valve, output_drain, motor}), 32'd0);
        step(5);
        checkOutput("g_fault_sticky", 32'(stage), 32'd7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("g_reset_stage", 32'(stage), 32'd0);
        checkOutput("g_reset_fault", 32'(fault), 32'd0);
`else
        // Without the watchdog FILL waits indefinitely and fault stays low
        mode = 2'd0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(100);
        checkOutput("g_fill_waits", 32'(stage), 32'd1);
        checkOutput("g_fill_valve", 32'(input_valve), 32'd1);
        checkOutput("g_no_fault", 32'(fault), 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("g_reset_stage", 32'(stage), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
